// File: rtl/el2_dccm_port_arb_if.sv
// ----------------------------------------------------------------------------
// el2_dccm_port_arb_if: LSU/DMA request ports and DCCM memory port bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface el2_dccm_port_arb_if #(
  parameter int DCCM_BITS = 16,
  parameter int DATA_W    = 39
);
  logic                 lsu_req;
  logic                 lsu_we;
  logic [DCCM_BITS-1:0] lsu_addr;
  logic [DATA_W-1:0]    lsu_wdata;
  logic                 lsu_gnt;
  logic                 lsu_rvalid;

  logic                 dma_req;
  logic                 dma_we;
  logic [DCCM_BITS-1:0] dma_addr;
  logic [DATA_W-1:0]    dma_wdata;
  logic                 dma_gnt;
  logic                 dma_rvalid;

  logic [DATA_W-1:0]    rd_data;
  logic                 dccm_wren;
  logic                 dccm_rden;
  logic [DCCM_BITS-1:0] dccm_addr;
  logic [DATA_W-1:0]    dccm_wr_data;
  logic [DATA_W-1:0]    dccm_rd_data;
  logic                 starve_boost;

  // Environment side: requesters plus memory wrapper.
  modport master (
    output lsu_req, lsu_we, lsu_addr, lsu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output dccm_rd_data,
    input  lsu_gnt, lsu_rvalid, dma_gnt, dma_rvalid, rd_data,
    input  dccm_wren, dccm_rden, dccm_addr, dccm_wr_data, starve_boost
  );

  // Arbiter side.
  modport slave (
    input  lsu_req, lsu_we, lsu_addr, lsu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  dccm_rd_data,
    output lsu_gnt, lsu_rvalid, dma_gnt, dma_rvalid, rd_data,
    output dccm_wren, dccm_rden, dccm_addr, dccm_wr_data, starve_boost
  );
endinterface

`default_nettype wire

// File: rtl/el2_dccm_port_arb.sv
// ----------------------------------------------------------------------------
// el2_dccm_port_arb: LSU/DMA DCCM port arbiter with starvation guard; optional DCCM_ARB_PERF_EN counters
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module el2_dccm_port_arb #(
  parameter int DCCM_BITS  = 16,
  parameter int DATA_W     = 39,
  parameter int STARVE_MAX = 4,
  parameter int RD_LAT     = 1
) (
  input  logic        clk,
  input  logic        rst_l,
`ifdef DCCM_ARB_PERF_EN
  output logic [15:0] conflict_cnt,
  output logic [15:0] boost_cnt,
`endif
  el2_dccm_port_arb_if.slave bus
);

  typedef enum logic [0:0] {
    NORMAL    = 1'b0,
    DMA_BOOST = 1'b1
  } state_t;

  localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

  state_t               r_state;
  logic [3:0]           r_starve;
  logic [RD_LAT-1:0]    r_tag_v;
  logic [RD_LAT-1:0]    r_tag_own;

  logic                 w_lsu_win;
  logic                 w_dma_win;
  logic                 w_conflict;
  logic                 w_enter_boost;
  logic [DCCM_BITS-1:0] w_addr;
  logic [DATA_W-1:0]    w_wdata;

  assign w_conflict    = bus.lsu_req & bus.dma_req;
  assign w_enter_boost = (r_state == NORMAL) & w_conflict & (r_starve == STARVE_LAST);

  // Grants are forced low while reset is asserted so every output reads 0.
  always_comb begin
    w_lsu_win = 1'b0;
    w_dma_win = 1'b0;
    if (rst_l) begin
      if (r_state == DMA_BOOST) begin
        w_dma_win = bus.dma_req;
        w_lsu_win = bus.lsu_req & ~bus.dma_req;
      end else begin
        w_lsu_win = bus.lsu_req;
        w_dma_win = bus.dma_req & ~bus.lsu_req;
      end
    end
  end

  assign w_addr  = ~rst_l ? '0 : (w_dma_win ? bus.dma_addr  : bus.lsu_addr);
  assign w_wdata = ~rst_l ? '0 : (w_dma_win ? bus.dma_wdata : bus.lsu_wdata);

  assign bus.lsu_gnt      = w_lsu_win;
  assign bus.dma_gnt      = w_dma_win;
  assign bus.dccm_wren    = (w_lsu_win & bus.lsu_we)  | (w_dma_win & bus.dma_we);
  assign bus.dccm_rden    = (w_lsu_win & ~bus.lsu_we) | (w_dma_win & ~bus.dma_we);
  assign bus.dccm_addr    = w_addr;
  assign bus.dccm_wr_data = w_wdata;
  assign bus.starve_boost = (r_state == DMA_BOOST);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state  <= NORMAL;
      r_starve <= 4'd0;
    end else if (r_state == DMA_BOOST) begin
      // One boosted grant, or DMA gave up: either way back to normal priority.
      r_state  <= NORMAL;
      r_starve <= 4'd0;
    end else if (w_dma_win) begin
      r_starve <= 4'd0;
    end else if (w_conflict) begin
      if (w_enter_boost) begin
        r_state <= DMA_BOOST;
      end
      if (r_starve != 4'hF) begin
        r_starve <= r_starve + 4'd1;
      end
    end
  end

  // Tag pipe: stage 0 captures this cycle's read, last stage lines up with memory data.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_tag_v[0]   <= 1'b0;
      r_tag_own[0] <= 1'b0;
    end else begin
      r_tag_v[0]   <= bus.dccm_rden;
      r_tag_own[0] <= w_dma_win;
    end
  end

  generate
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_tag_stage
      always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
          r_tag_v[gi]   <= 1'b0;
          r_tag_own[gi] <= 1'b0;
        end else begin
          r_tag_v[gi]   <= r_tag_v[gi-1];
          r_tag_own[gi] <= r_tag_own[gi-1];
        end
      end
    end
  endgenerate

  assign bus.lsu_rvalid = r_tag_v[RD_LAT-1] & ~r_tag_own[RD_LAT-1];
  assign bus.dma_rvalid = r_tag_v[RD_LAT-1] &  r_tag_own[RD_LAT-1];
  assign bus.rd_data    = rst_l ? bus.dccm_rd_data : '0;

`ifdef DCCM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      conflict_cnt <= 16'd0;
      boost_cnt    <= 16'd0;
    end else begin
      if (w_conflict && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
      if (w_enter_boost && (boost_cnt != 16'hFFFF)) begin
        boost_cnt <= boost_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/el2_dccm_port_arb.md
Name: el2_dccm_port_arb

Overview:
- Fixed-priority arbiter with a starvation guard. Shares the single DCCM read/write port between the LSU (requester 0) and the DMA slave (requester 1).
- Issues one access per cycle to the DCCM memory wrapper (dccm_wren/dccm_rden/address/data).
- Tracks outstanding reads through a latency-matched tag pipe and routes returning read data to the requester that issued the read.
- Sits between lsu_dccm_ctl / dma_ctrl and el2_mem.

Parameters:
- DCCM_BITS, 16, DCCM byte-address width.
- DATA_W, 39, DCCM word width including ECC (DCCM_FDATA_WIDTH).
- STARVE_MAX, 4, consecutive DMA losses that force one DMA-priority grant; legal range 1..15.
- RD_LAT, 1, cycles from dccm_rden to valid dccm_rd_data; legal values 1 or 2.

Ports:
- clk  in  1  core clock
- rst_l  in  1  asynchronous active-low reset
- lsu_req  in  1  LSU access request
- lsu_we  in  1  1=write, 0=read
- lsu_addr  in  DCCM_BITS  LSU address
- lsu_wdata  in  DATA_W  LSU write data
- lsu_gnt  out  1  LSU request accepted this cycle
- lsu_rvalid  out  1  LSU read data valid
- dma_req  in  1  DMA access request
- dma_we  in  1  1=write, 0=read
- dma_addr  in  DCCM_BITS  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA request accepted this cycle
- dma_rvalid  out  1  DMA read data valid
- rd_data  out  DATA_W  read data, shared by both requesters, qualified by the rvalids
- dccm_wren  out  1  to memory
- dccm_rden  out  1  to memory
- dccm_addr  out  DCCM_BITS  drives both rd and wr address
- dccm_wr_data  out  DATA_W  to memory
- dccm_rd_data  in  DATA_W  from memory
- starve_boost  out  1  FSM is in the DMA_BOOST state (debug)

Behaviour:
- Reset (async assert, sync deassert via rst_l): all outputs 0; FSM=NORMAL; starvation counter=0; tag pipe cleared.
- Arbitration is combinational within the cycle. A grant is issued in the same cycle as the request. Requesters hold req/we/addr/wdata stable until granted.
- Exactly one grant per cycle at most; lsu_gnt & dma_gnt is never 1.
- The dccm_* outputs are combinational from the winning requester's fields. dccm_wren = gnt & we; dccm_rden = gnt & ~we.
- FSM NORMAL:
  - LSU wins whenever lsu_req=1.
  - Cycle with dma_req & lsu_req: DMA loses, starvation counter increments.
  - Counter reaching STARVE_MAX-1 on a loss: next state DMA_BOOST.
  - Any DMA grant clears the counter.
- FSM DMA_BOOST:
  - DMA wins if dma_req=1; LSU is stalled.
  - After one DMA grant: return to NORMAL, counter=0.
  - If dma_req drops while in DMA_BOOST: return to NORMAL, counter=0, and LSU is granted the same cycle if requesting.
- Starvation counter is 4 bits and saturates; it never wraps.
- Tag pipe:
  - Depth RD_LAT, entries {valid, owner}. Pushed every cycle with {dccm_rden, owner}.
  - Output stage drives lsu_rvalid = valid & owner==0, dma_rvalid = valid & owner==1.
  - rd_data = dccm_rd_data, passed through.
- Back-to-back reads from alternating owners return in issue order, one per cycle, with no bubbles.
- A write issued one cycle after a read does not disturb the read return.
- Reset mid-operation: pending tag-pipe entries are discarded; no rvalid is produced for reads issued before reset.
- No request (both idle): all dccm_* strobes 0; the address/data outputs hold the LSU fields, for determinism.

Optional Feature:
- Macro: DCCM_ARB_PERF_EN.
- When defined:
  - Adds output conflict_cnt[15:0]: a saturating count of cycles with lsu_req & dma_req. Stops at 16'hFFFF.
  - Adds output boost_cnt[15:0]: a saturating count of entries into DMA_BOOST.
  - Both counters reset to 0.
- When undefined: neither port nor either counter exists. Arbitration behaviour is identical.

Test Plan:
- Reset with both requesters requesting reads, then deassert rst_l: first cycle, lsu_gnt=1, dccm_rden=1, dccm_addr=lsu_addr. With RD_LAT=1, the next cycle gives lsu_rvalid=1 and rd_data=memory word.
- Continuous lsu_req and dma_req, STARVE_MAX=4: grant pattern is LSU,LSU,LSU,LSU,DMA repeating. starve_boost=1 only in the DMA cycle.
- DMA alone writes 0x12345 to addr 0x0040: dma_gnt=1 and dccm_wren=1 the same cycle, no rvalid. A DMA read of 0x0040 then returns dma_rvalid with 0x12345.
- RD_LAT=2, alternating reads LSU@0x10, DMA@0x20, LSU@0x30: rvalids arrive 2 cycles after each issue, in order L,D,L, with the correct data for each.
- DMA_BOOST entered, then dma_req drops: same cycle, FSM returns to NORMAL and LSU is granted; counter=0.
- Assert rst_l=0 one cycle after a read grant: no rvalid afterwards; all outputs 0 while in reset.
- DCCM_ARB_PERF_EN: 70000 conflict cycles -> conflict_cnt=16'hFFFF (saturated).
